// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - register offsets, CTRL layout, modes and FSM states for timer_dev
package timer_dev_pkg;

  localparam logic [1:0] TIM_CTRL   = 2'd0;
  localparam logic [1:0] TIM_PRESET = 2'd1;
  localparam logic [1:0] TIM_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tim_state_e;

  // Field order mirrors CTRL bits [3:0]: IM, MODE[1:0], EN.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tim_ctrl_t;

endpackage

// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - word load/store port between the data-memory bridge and a timer
interface timer_dev_if;
  logic [29:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with CTRL/PRESET/COUNT and masked irq
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  timer_dev_if.slave  bus,
  output logic        irq
);

  tim_ctrl_t   ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  tim_state_e  state_q, state_d;
  logic        irq_flag_q, irq_flag_d;

  logic [1:0] off;
  logic       wr_ctrl, wr_preset, en_eff;
  logic       unused_addr;

  assign off         = bus.addr[1:0];
  assign unused_addr = ^bus.addr[29:2];
  assign wr_ctrl     = bus.we && (off == TIM_CTRL);
  assign wr_preset   = bus.we && (off == TIM_PRESET);
  // A CTRL write is seen by the FSM in the same cycle, so a stop freezes COUNT immediately.
  assign en_eff      = wr_ctrl ? bus.din[CTRL_EN] : ctrl_q.en;

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;
    case (state_q)
      ST_IDLE: if (en_eff) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_eff) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_RELOAD) irq_flag_d = 1'b0;
        else                            ctrl_d.en  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Bus writes override whatever the FSM did to CTRL/irq_flag this cycle.
    if (wr_ctrl) begin
      ctrl_d     = tim_ctrl_t'(bus.din[3:0]);
      irq_flag_d = 1'b0;
    end
    if (wr_preset) preset_d = bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    bus.dout = 32'd0;
    case (off)
      TIM_CTRL:   bus.dout = {28'd0, ctrl_q};
      TIM_PRESET: bus.dout = preset_q;
      TIM_COUNT:  bus.dout = count_q;
      default:    bus.dout = 32'd0;
    endcase
  end

  assign irq = ctrl_q.im & irq_flag_q;

endmodule
